// File: rtl/mult16u_product_acc.sv
// Group-wise accumulator for the 32-bit unsigned product stream, with a valid/ready result port.
// Define MULT16U_PRODUCT_ACC_SAT_EN to clamp the sum on overflow instead of wrapping.
module mult16u_product_acc #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_reg, state_next;

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic [ACC_W-1:0] sum_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_out_reg;

  logic             acc_fire;
  logic [ACC_W:0]   add_full;
  logic             carry;
  logic             ovf_new;
  logic [ACC_W-1:0] acc_new;
  logic [CNT_W-1:0] cnt_new;

  assign acc_fire = in_valid & in_ready;
  assign add_full = {1'b0, acc_reg} + {{(ACC_W + 1 - 32){1'b0}}, in_product};
  assign carry    = add_full[ACC_W];
  assign ovf_new  = ovf_reg | carry;

`ifdef MULT16U_PRODUCT_ACC_SAT_EN
  // Once the group has overflowed, the sum is pinned at full scale.
  assign acc_new = ovf_new ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
  assign acc_new = add_full[ACC_W-1:0];
`endif

  assign cnt_new = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  // Handshake outputs depend on state only; rst masks them so nothing fires during reset.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready = ~rst;
        if (in_valid & ~rst & in_last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = ~rst;
        if (out_ready & ~rst) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      sum_reg     <= '0;
      count_reg   <= '0;
      ovf_out_reg <= 1'b0;
    end else if (acc_fire) begin
      if (in_last) begin
        sum_reg     <= acc_new;
        count_reg   <= cnt_new;
        ovf_out_reg <= ovf_new;
        acc_reg     <= '0;
        cnt_reg     <= '0;
        ovf_reg     <= 1'b0;
      end else begin
        acc_reg <= acc_new;
        cnt_reg <= cnt_new;
        ovf_reg <= ovf_new;
      end
    end
  end

  assign out_sum   = sum_reg;
  assign out_count = count_reg;
  assign out_ovf   = ovf_out_reg;

endmodule

// File: tb/tb_mult16u_product_acc.sv
// Bench for mult16u_product_acc: a wide (40/8) and a narrow (33/2) instance share one stimulus
// stream and are checked every cycle against a group-level arithmetic model.
module tb_mult16u_product_acc;

`ifdef MULT16U_PRODUCT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_product;
  logic        in_last;
  logic        out_ready;

  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [39:0] b_out_sum;
  logic [7:0]  b_out_count;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [32:0] s_out_sum;
  logic [1:0]  s_out_count;

  int vectors = 0;
  int miscompares = 0;

  mult16u_product_acc #(.ACC_W(40), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  mult16u_product_acc #(.ACC_W(33), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_sum(s_out_sum), .out_count(s_out_count), .out_ovf(s_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Group result from the exact integer total of its terms.
  function automatic logic [63:0] f_sum(input logic [127:0] t, input int w);
    logic [127:0] mx;
    logic [127:0] r;
    mx = (128'd1 << w) - 128'd1;
    if (t > mx) r = SAT ? mx : (t & mx);
    else        r = t;
    return r[63:0];
  endfunction

  function automatic logic f_ovf(input logic [127:0] t, input int w);
    logic [127:0] mx;
    mx = (128'd1 << w) - 128'd1;
    return t > mx;
  endfunction

  function automatic int f_cnt(input int n, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Model: exact running total and term count of the open group, plus the held result.
  logic         m_hold  = 1'b0;
  logic [127:0] m_total = '0;
  int           m_n     = 0;
  logic [63:0]  eb_sum  = '0;
  logic [63:0]  es_sum  = '0;
  int           eb_cnt  = 0;
  int           es_cnt  = 0;
  logic         eb_ovf  = 1'b0;
  logic         es_ovf  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_hold <= 1'b0; m_total <= '0; m_n <= 0;
      eb_sum <= '0; eb_cnt <= 0; eb_ovf <= 1'b0;
      es_sum <= '0; es_cnt <= 0; es_ovf <= 1'b0;
    end else if (!m_hold) begin
      if (in_valid) begin
        if (in_last) begin
          m_hold  <= 1'b1;
          m_total <= '0;
          m_n     <= 0;
          eb_sum  <= f_sum(m_total + 128'(in_product), 40);
          eb_ovf  <= f_ovf(m_total + 128'(in_product), 40);
          eb_cnt  <= f_cnt(m_n + 1, 8);
          es_sum  <= f_sum(m_total + 128'(in_product), 33);
          es_ovf  <= f_ovf(m_total + 128'(in_product), 33);
          es_cnt  <= f_cnt(m_n + 1, 2);
        end else begin
          m_total <= m_total + 128'(in_product);
          m_n     <= m_n + 1;
        end
      end
    end else if (out_ready) begin
      m_hold <= 1'b0;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("b_in_ready",  64'(b_in_ready),  64'(!rst && !m_hold));
      check("b_out_valid", 64'(b_out_valid), 64'(!rst && m_hold));
      check("b_out_sum",   64'(b_out_sum),   eb_sum);
      check("b_out_count", 64'(b_out_count), 64'(eb_cnt));
      check("b_out_ovf",   64'(b_out_ovf),   64'(eb_ovf));
      check("s_in_ready",  64'(s_in_ready),  64'(!rst && !m_hold));
      check("s_out_valid", 64'(s_out_valid), 64'(!rst && m_hold));
      check("s_out_sum",   64'(s_out_sum),   es_sum);
      check("s_out_count", 64'(s_out_count), 64'(es_cnt));
      check("s_out_ovf",   64'(s_out_ovf),   64'(es_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p, input logic last);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    step();
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_product = '0; in_last = 1'b0; out_ready = 1'b1;

    // reset then idle
    step();
    @(negedge clk);
    check("lit_rst_in_ready",  64'(b_in_ready),  64'd0);
    check("lit_rst_out_valid", 64'(b_out_valid), 64'd0);
    check("lit_rst_out_sum",   64'(b_out_sum),   64'd0);
    check("lit_rst_out_count", 64'(b_out_count), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("lit_post_rst_in_ready", 64'(b_in_ready), 64'd1);
    $display("txn reset: done");

    // three-term group, sink always ready
    send(32'hFFFE0001, 1'b0);
    send(32'hFFFE0001, 1'b0);
    send(32'hFFFE0001, 1'b1);
    @(negedge clk);
    check("lit_g3_out_valid", 64'(b_out_valid), 64'd1);
    check("lit_g3_out_sum",   64'(b_out_sum),   64'h2_FFFA_0003);
    check("lit_g3_out_count", 64'(b_out_count), 64'd3);
    check("lit_g3_out_ovf",   64'(b_out_ovf),   64'd0);
    step();
    @(negedge clk);
    check("lit_g3_valid_drop", 64'(b_out_valid), 64'd0);
    $display("txn group3: sum=0x%0h count=%0d", b_out_sum, b_out_count);

    // backpressure with the next term held valid
    out_ready = 1'b0;
    send(32'd5, 1'b1);
    in_valid = 1'b1; in_product = 32'd9; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_bp_out_valid", 64'(b_out_valid), 64'd1);
      check("lit_bp_in_ready",  64'(b_in_ready),  64'd0);
      check("lit_bp_out_sum",   64'(b_out_sum),   64'd5);
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("lit_bp_after_fire_in_ready", 64'(b_in_ready),  64'd1);
    check("lit_bp_after_fire_valid",    64'(b_out_valid), 64'd0);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("lit_bp_held_out_valid", 64'(b_out_valid), 64'd1);
    check("lit_bp_held_out_sum",   64'(b_out_sum),   64'd9);
    step();
    $display("txn backpressure: held term sum=%0d", b_out_sum);

    // overflow on the 33-bit instance
    send(32'hFFFFFFFF, 1'b0);
    send(32'hFFFFFFFF, 1'b0);
    send(32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    check("lit_ovf_s_out_sum", 64'(s_out_sum), SAT ? 64'h1_FFFF_FFFF : 64'h0_FFFF_FFFD);
    check("lit_ovf_s_out_ovf", 64'(s_out_ovf), 64'd1);
    check("lit_ovf_b_out_ovf", 64'(b_out_ovf), 64'd0);
    step();
    $display("txn overflow: s_sum=0x%0h s_ovf=%0d", s_out_sum, s_out_ovf);

    // count saturation on the 2-bit counter
    for (int i = 0; i < 4; i++) send(32'd1, 1'b0);
    send(32'd1, 1'b1);
    @(negedge clk);
    check("lit_cnt_s_out_count", 64'(s_out_count), 64'd3);
    check("lit_cnt_s_out_sum",   64'(s_out_sum),   64'd5);
    check("lit_cnt_b_out_count", 64'(b_out_count), 64'd5);
    step();
    $display("txn countsat: s_count=%0d b_count=%0d", s_out_count, b_out_count);

    // reset mid-group discards the partial sum
    send(32'd100, 1'b0);
    send(32'd100, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("lit_midrst_in_ready",  64'(b_in_ready),  64'd1);
    check("lit_midrst_out_valid", 64'(b_out_valid), 64'd0);
    send(32'd7, 1'b1);
    @(negedge clk);
    check("lit_midrst_out_sum",   64'(b_out_sum),   64'd7);
    check("lit_midrst_out_count", 64'(b_out_count), 64'd1);
    step();
    $display("txn midreset: sum=%0d count=%0d", b_out_sum, b_out_count);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
